mpu6050_sample_assembler: RTL

MPU6050_SAMPLE_ASSEMBLER -- requirements
Module: mpu6050_sample_assembler

---
 rtl/mpu6050_sample_assembler.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/mpu6050_sample_assembler.sv
// MPU6050 sample assembler.
// Collects the 14 bytes of one sensor burst (accel xyz, temp, gyro xyz, big
// endian) written slot by slot by an I2C controller, then publishes them as
// seven signed words when the burst completes with every slot present. After
// each burst it idles RESCAN_INTERVAL cycles and asks the controller for the
// next one. Accel X/Y also drive hysteretic tilt flags.
//
// Ports
//   clk, reset_n         clock, async active-low reset
//   address[3:0], data   slot index / byte value, written while load=1
//   load                 slot write strobe
//   completed            controller holds a finished burst (level)
//   rescan               request for the next burst (level, RESCAN state only)
//   accel_*/temp/gyro_*  published signed sample words
//   sample_valid         1-cycle pulse: new sample published
//   frame_error          1-cycle pulse: burst ended with missing slots
//   tilt_*               hysteretic tilt flags from accel_x / accel_y
//   frame_count[7:0]     number of published samples, wrapping
module mpu6050_sample_assembler #(
  parameter int RESCAN_INTERVAL = 2500000,
  parameter int TILT_ON         = 4096,
  parameter int TILT_OFF        = 2048
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [3:0]         address,
  input  logic [7:0]         data,
  input  logic               load,
  input  logic               completed,
  output logic               rescan,
  output logic signed [15:0] accel_x,
  output logic signed [15:0] accel_y,
  output logic signed [15:0] accel_z,
  output logic signed [15:0] temp,
  output logic signed [15:0] gyro_x,
  output logic signed [15:0] gyro_y,
  output logic signed [15:0] gyro_z,
  output logic               sample_valid,
  output logic               frame_error,
  output logic               tilt_left,
  output logic               tilt_right,
  output logic               tilt_fwd,
  output logic               tilt_back,
  output logic [7:0]         frame_count
);

  localparam int         NUM_SLOTS = 14;
  localparam int         NUM_WORDS = 7;
  localparam logic [31:0] CNT_LAST = 32'(RESCAN_INTERVAL - 1);

  typedef enum logic [1:0] {S_COLLECT, S_PUBLISH, S_WAIT, S_RESCAN} state_e;

  state_e                            state_q, state_d;
  logic [31:0]                       cnt_q, cnt_d;
  logic                              comp_prev_q;
  logic [NUM_SLOTS-1:0][7:0]         slot_q;
  logic [NUM_SLOTS-1:0]              mask_q;
  logic [NUM_WORDS-1:0][15:0]        word_q, word_w;
  logic                              sv_q, fe_q, rescan_q;
  logic                              tl_q, tr_q, tf_q, tb_q;
  logic                              tl_d, tr_d, tf_d, tb_d;
  logic [7:0]                        fc_q;
  logic                              mask_full;
  logic                              slot_wr;
  int                                ax_i, ay_i;

  assign mask_full = &mask_q;
  assign slot_wr   = (state_q == S_COLLECT) && load && (address <= 4'd13);

  // Word k is the big-endian pair {slot[2k], slot[2k+1]}.
  for (genvar k = 0; k < NUM_WORDS; k++) begin : g_word
    assign word_w[k] = {slot_q[2*k], slot_q[2*k+1]};
  end

  // ---------------------------------------------------------------- FSM
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_COLLECT: if (completed && !comp_prev_q) state_d = S_PUBLISH;
      S_PUBLISH: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        if (cnt_q == CNT_LAST) state_d = S_RESCAN;
        else                   cnt_d   = cnt_q + 32'd1;
      end
      S_RESCAN: if (!completed) state_d = S_COLLECT;
      default:  state_d = S_COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_COLLECT;
      cnt_q       <= '0;
      comp_prev_q <= 1'b0;
      rescan_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      comp_prev_q <= completed;
      // Registered from next state so rescan tracks the RESCAN state exactly.
      rescan_q    <= (state_d == S_RESCAN);
    end
  end

  // ------------------------------------------------------ slot storage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_q <= '0;
      mask_q <= '0;
    end else begin
      if (slot_wr) begin
        slot_q[address] <= data;
        mask_q[address] <= 1'b1;
      end
      // Leaving RESCAN starts a fresh burst.
      if (state_q == S_RESCAN && !completed) mask_q <= '0;
    end
  end

  // ------------------------------------------------------ tilt next state
  // Thresholds are applied to the words about to be published.
  always_comb begin
    ax_i = int'($signed(word_w[0]));
    ay_i = int'($signed(word_w[1]));
    tr_d = tr_q;
    tl_d = tl_q;
    tf_d = tf_q;
    tb_d = tb_q;
    if (ax_i > TILT_ON)        tr_d = 1'b1;
    else if (ax_i < TILT_OFF)  tr_d = 1'b0;
    if (ax_i < -TILT_ON)       tl_d = 1'b1;
    else if (ax_i > -TILT_OFF) tl_d = 1'b0;
    if (ay_i > TILT_ON)        tf_d = 1'b1;
    else if (ay_i < TILT_OFF)  tf_d = 1'b0;
    if (ay_i < -TILT_ON)       tb_d = 1'b1;
    else if (ay_i > -TILT_OFF) tb_d = 1'b0;
  end

  // ------------------------------------------------------ publish
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_q <= '0;
      sv_q   <= 1'b0;
      fe_q   <= 1'b0;
      fc_q   <= '0;
      tl_q   <= 1'b0;
      tr_q   <= 1'b0;
      tf_q   <= 1'b0;
      tb_q   <= 1'b0;
    end else begin
      sv_q <= 1'b0;
      fe_q <= 1'b0;
      if (state_q == S_PUBLISH) begin
        if (mask_full) begin
          word_q <= word_w;
          sv_q   <= 1'b1;
          fc_q   <= fc_q + 8'd1;
          tl_q   <= tl_d;
          tr_q   <= tr_d;
          tf_q   <= tf_d;
          tb_q   <= tb_d;
        end else begin
          fe_q   <= 1'b1;
        end
      end
    end
  end

  assign accel_x      = word_q[0];
  assign accel_y      = word_q[1];
  assign accel_z      = word_q[2];
  assign temp         = word_q[3];
  assign gyro_x       = word_q[4];
  assign gyro_y       = word_q[5];
  assign gyro_z       = word_q[6];
  assign sample_valid = sv_q;
  assign frame_error  = fe_q;
  assign rescan       = rescan_q;
  assign tilt_left    = tl_q;
  assign tilt_right   = tr_q;
  assign tilt_fwd     = tf_q;
  assign tilt_back    = tb_q;
  assign frame_count  = fc_q;

endmodule
